// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding scoreboard beside ID: tracks in-flight destinations and picks forward sources or stalls.
// Define HAZ_FORWARD_EN for per-latency forwarding; left undefined, any in-flight match stalls and fwd sels are 0.
module pipe_hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 5,
  parameter int ALU_LAT    = 1,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_flush,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_rf_we,
  input  logic [ADDR_W-1:0] id_rf_waddr,
  input  logic              id_is_load,
  output logic              stall,
  output logic              id_issue,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [CNT_W-1:0]  stall_count
);

`ifdef HAZ_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [NUM_STAGES-1:0] we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q [NUM_STAGES];
  logic [ADDR_W-1:0]     waddr_d [NUM_STAGES];
  logic [SEL_W-1:0]      lat_q   [NUM_STAGES];
  logic [SEL_W-1:0]      lat_d   [NUM_STAGES];
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;

  logic             rs_hit, rs_ready, rt_hit, rt_ready;
  logic [SEL_W-1:0] rs_idx, rt_idx;
  logic             rs_block, rt_block;

  // Scan oldest to youngest so the youngest matching entry overwrites older ones.
  always_comb begin
    rs_hit   = 1'b0;
    rs_ready = 1'b0;
    rs_idx   = '0;
    rt_hit   = 1'b0;
    rt_ready = 1'b0;
    rt_idx   = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (v_q[k] && we_q[k] && (waddr_q[k] == id_rs) && (id_rs != '0)) begin
        rs_hit   = 1'b1;
        rs_ready = (SEL_W'(k) >= lat_q[k]);
        rs_idx   = SEL_W'(k + 1);
      end
      if (v_q[k] && we_q[k] && (waddr_q[k] == id_rt) && (id_rt != '0)) begin
        rt_hit   = 1'b1;
        rt_ready = (SEL_W'(k) >= lat_q[k]);
        rt_idx   = SEL_W'(k + 1);
      end
    end
  end

  always_comb begin
    rs_block   = rs_hit & ~(FWD_EN & rs_ready);
    rt_block   = rt_hit & ~(FWD_EN & rt_ready);
    stall      = ~reset & id_valid & ~id_flush &
                 ((id_use_rs & rs_block) | (id_use_rt & rt_block));
    id_issue   = ~reset & id_valid & ~id_flush & ~stall;
    fwd_rs_sel = (FWD_EN && !reset) ? rs_idx : '0;
    fwd_rt_sel = (FWD_EN && !reset) ? rt_idx : '0;
  end

  always_comb begin
    v_d[0]     = id_issue;
    we_d[0]    = id_rf_we;
    waddr_d[0] = id_rf_waddr;
    lat_d[0]   = id_is_load ? SEL_W'(LOAD_LAT) : SEL_W'(ALU_LAT);
    for (int k = 1; k < NUM_STAGES; k++) begin
      v_d[k]     = v_q[k-1];
      we_d[k]    = we_q[k-1];
      waddr_d[k] = waddr_q[k-1];
      lat_d[k]   = lat_q[k-1];
    end
    stall_count_d = (stall && (stall_count_q != '1)) ? stall_count_q + CNT_W'(1) : stall_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q           <= '0;
      stall_count_q <= '0;
    end else begin
      v_q           <= v_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Payload fields are qualified by v, so they need no reset.
  always_ff @(posedge clock) begin
    we_q    <= we_d;
    waddr_q <= waddr_d;
    lat_q   <= lat_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Randomized and directed bench for pipe_hazard_scoreboard against a timestamp-based reference model.
// Expectations adapt to whether HAZ_FORWARD_EN is defined.
module tb_pipe_hazard_scoreboard;
  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int CW  = 4;
  localparam int SW  = $clog2(NS + 1);
  localparam int ALU = 1;
  localparam int LD  = 2;
`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0, id_flush = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rf_waddr = '0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0, id_rf_we = 1'b0, id_is_load = 1'b0;
  logic          stall, id_issue;
  logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;
  logic [CW-1:0] stall_count;

  pipe_hazard_scoreboard #(
    .NUM_STAGES(NS), .ADDR_W(AW), .ALU_LAT(ALU), .LOAD_LAT(LD), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr), .id_is_load(id_is_load),
    .stall(stall), .id_issue(id_issue), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // Reference model: issued instructions with their issue cycle; age and readiness follow from timestamps.
  typedef struct {
    logic [AW-1:0] waddr;
    bit            we;
    int            lat;
    int            issue_cyc;
  } instr_t;

  instr_t inflight[$];
  int cyc = 0;
  int exp_count = 0;
  bit exp_stall, exp_issue;
  int exp_rs_sel, exp_rt_sel;
  int vectors = 0;
  int miscompares = 0;

  function automatic void lookup(input logic [AW-1:0] src, output bit blocked, output int sel);
    int best_age;
    bit ready;
    int age;
    best_age = -1;
    ready    = 1'b0;
    foreach (inflight[i]) begin
      age = cyc - inflight[i].issue_cyc - 1;
      if (inflight[i].we && src != '0 && inflight[i].waddr == src && (best_age < 0 || age < best_age)) begin
        best_age = age;
        ready    = (cyc >= inflight[i].issue_cyc + 1 + inflight[i].lat);
      end
    end
    blocked = (best_age >= 0) && (!FWD || !ready);
    sel     = (FWD && best_age >= 0) ? best_age + 1 : 0;
  endfunction

  task automatic model_eval;
    bit brs, brt;
    int srs, srt;
    lookup(id_rs, brs, srs);
    lookup(id_rt, brt, srt);
    exp_stall  = !reset && id_valid && !id_flush && ((id_use_rs && brs) || (id_use_rt && brt));
    exp_issue  = !reset && id_valid && !id_flush && !exp_stall;
    exp_rs_sel = reset ? 0 : srs;
    exp_rt_sel = reset ? 0 : srt;
  endtask

  task automatic drive(input int rst, input int v, input int f, input int rs, input int rt,
                       input int urs, input int urt, input int we, input int wa, input int ld);
    @(negedge clock);
    reset       = (rst != 0);
    id_valid    = (v != 0);
    id_flush    = (f != 0);
    id_rs       = AW'(rs);
    id_rt       = AW'(rt);
    id_use_rs   = (urs != 0);
    id_use_rt   = (urt != 0);
    id_rf_we    = (we != 0);
    id_rf_waddr = AW'(wa);
    id_is_load  = (ld != 0);
    #1;
    model_eval();
  endtask

  task automatic tick;
    @(posedge clock);
    if (reset) begin
      inflight.delete();
      exp_count = 0;
    end else begin
      if (exp_stall && exp_count < (2 ** CW) - 1) exp_count++;
      if (exp_issue) inflight.push_back('{id_rf_waddr, id_rf_we, (id_is_load ? LD : ALU), cyc});
    end
    cyc++;
    while (inflight.size() > 0 && cyc - inflight[0].issue_cyc - 1 >= NS) void'(inflight.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic issue_instr(input int wa, input int ld);
    drive(0, 1, 0, 0, 0, 0, 0, 1, wa, ld);
    tick();
  endtask

  // Holds a non-writing consumer in ID until the DUT issues it (bounded); reports what the DUT did.
  task automatic run_consumer(input int rs, input int rt, input int urs, input int urt,
                              output int stalls, output int rs_o, output int rt_o,
                              output bit issued, output int bad);
    int n;
    stalls = 0; rs_o = -1; rt_o = -1; issued = 1'b0; bad = 0; n = 0;
    while (!issued && n < 12) begin
      drive(0, 1, 0, rs, rt, urs, urt, 0, 0, 0);
      if (stall !== exp_stall || id_issue !== exp_issue) bad++;
      if (stall === 1'b1) stalls++;
      if (id_issue === 1'b1) begin
        issued = 1'b1;
        rs_o   = int'(fwd_rs_sel);
        rt_o   = int'(fwd_rt_sel);
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (2) begin
      drive(1, 1, 0, 3, 4, 1, 1, 1, 3, 0);
      vectors++;
      if (stall !== 1'b0 || id_issue !== 1'b0 || fwd_rs_sel !== '0 || fwd_rt_sel !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs got stall=%b issue=%b rs=%0d rt=%0d exp all 0", stall, id_issue, fwd_rs_sel, fwd_rt_sel);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (stall_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_count got=%0d exp=0", stall_count);
    end
    tick();
  endtask

  task automatic test_alu_dep;
    int st, rso, rto, bad;
    bit iss;
    issue_instr(3, 0);
    run_consumer(3, 0, 1, 0, st, rso, rto, iss, bad);
    vectors++;
    if (!iss || bad != 0) begin
      miscompares++;
      $display("[TB] FAIL alu_dep_flow got issued=%0d badcycles=%0d exp issued=1 badcycles=0", iss, bad);
    end
    vectors++;
    if (st != (FWD ? 1 : 3)) begin
      miscompares++;
      $display("[TB] FAIL alu_dep_stalls got=%0d exp=%0d", st, FWD ? 1 : 3);
    end
    vectors++;
    if (rso != (FWD ? 2 : 0)) begin
      miscompares++;
      $display("[TB] FAIL alu_dep_rs_sel got=%0d exp=%0d", rso, FWD ? 2 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (stall_count !== CW'(FWD ? 1 : 3)) begin
      miscompares++;
      $display("[TB] FAIL alu_dep_count got=%0d exp=%0d", stall_count, FWD ? 1 : 3);
    end
    tick();
    idle(NS);
  endtask

  task automatic test_load_dep;
    int st, rso, rto, bad, base;
    bit iss;
    base = exp_count;
    issue_instr(5, 1);
    run_consumer(0, 5, 0, 1, st, rso, rto, iss, bad);
    vectors++;
    if (!iss || bad != 0) begin
      miscompares++;
      $display("[TB] FAIL load_dep_flow got issued=%0d badcycles=%0d exp issued=1 badcycles=0", iss, bad);
    end
    vectors++;
    if (st != (FWD ? 2 : 3) || rto != (FWD ? 3 : 0)) begin
      miscompares++;
      $display("[TB] FAIL load_dep got stalls=%0d rt_sel=%0d exp stalls=%0d rt_sel=%0d", st, rto, FWD ? 2 : 3, FWD ? 3 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (stall_count !== CW'(base + (FWD ? 2 : 3))) begin
      miscompares++;
      $display("[TB] FAIL load_dep_count got=%0d exp=%0d", stall_count, base + (FWD ? 2 : 3));
    end
    tick();
    idle(NS);
  endtask

  task automatic test_youngest;
    int st, rso, rto, bad;
    bit iss;
    issue_instr(4, 0);
    issue_instr(4, 0);
    idle(1);
    run_consumer(4, 0, 1, 0, st, rso, rto, iss, bad);
    vectors++;
    if (!iss || bad != 0 || st != (FWD ? 0 : 2) || rso != (FWD ? 2 : 0)) begin
      miscompares++;
      $display("[TB] FAIL youngest_wins got issued=%0d bad=%0d stalls=%0d rs_sel=%0d exp 1/0/%0d/%0d",
               iss, bad, st, rso, FWD ? 0 : 2, FWD ? 2 : 0);
    end
    idle(NS);
  endtask

  task automatic test_reg_zero;
    int st, rso, rto, bad;
    bit iss;
    issue_instr(0, 0);
    issue_instr(0, 1);
    run_consumer(0, 0, 1, 1, st, rso, rto, iss, bad);
    vectors++;
    if (!iss || bad != 0 || st != 0 || rso != 0 || rto != 0) begin
      miscompares++;
      $display("[TB] FAIL reg_zero got issued=%0d bad=%0d stalls=%0d rs_sel=%0d rt_sel=%0d exp 1/0/0/0/0",
               iss, bad, st, rso, rto);
    end
    idle(NS);
  endtask

  task automatic test_flush_reset;
    issue_instr(6, 1);
    drive(0, 1, 1, 0, 6, 0, 1, 0, 0, 0);
    vectors++;
    if (stall !== 1'b0 || id_issue !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_priority got stall=%b issue=%b exp 0 0", stall, id_issue);
    end
    tick();
    drive(1, 1, 0, 0, 6, 0, 1, 0, 0, 0);
    vectors++;
    if (stall !== 1'b0 || id_issue !== 1'b0 || fwd_rs_sel !== '0 || fwd_rt_sel !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_midop got stall=%b issue=%b rs=%0d rt=%0d exp all 0", stall, id_issue, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
    drive(0, 1, 0, 0, 6, 0, 1, 0, 0, 0);
    vectors++;
    if (stall !== 1'b0 || id_issue !== 1'b1 || stall_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_drops_entries got stall=%b issue=%b count=%0d exp 0 1 0", stall, id_issue, stall_count);
    end
    tick();
    idle(NS);
  endtask

  task automatic test_random;
    int rs, rt, wa;
    for (int i = 0; i < 400; i++) begin
      rs = $urandom_range(0, 3);
      rt = $urandom_range(0, 3);
      wa = $urandom_range(0, 3);
      drive(($urandom_range(0, 49) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0, rs, rt, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), wa, $urandom_range(0, 1));
      vectors++;
      if (stall !== exp_stall || id_issue !== exp_issue) begin
        miscompares++;
        $display("[TB] FAIL rand_ctrl cyc=%0d got stall=%b issue=%b exp stall=%b issue=%b", cyc, stall, id_issue, exp_stall, exp_issue);
      end
      vectors++;
      if ((id_valid && id_use_rs && fwd_rs_sel !== SW'(exp_rs_sel)) ||
          (id_valid && id_use_rt && fwd_rt_sel !== SW'(exp_rt_sel))) begin
        miscompares++;
        $display("[TB] FAIL rand_fwd cyc=%0d got rs=%0d rt=%0d exp rs=%0d rt=%0d", cyc, fwd_rs_sel, fwd_rt_sel, exp_rs_sel, exp_rt_sel);
      end
      vectors++;
      if (stall_count !== CW'(exp_count)) begin
        miscompares++;
        $display("[TB] FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, stall_count, exp_count);
      end
      tick();
    end
    idle(NS);
  endtask

  task automatic test_saturation;
    int st, rso, rto, bad, total_bad, total_st;
    bit iss;
    total_bad = 0;
    total_st  = 0;
    repeat (8) begin
      issue_instr(9, 1);
      run_consumer(0, 9, 0, 1, st, rso, rto, iss, bad);
      total_bad += bad + (iss ? 0 : 1);
      total_st  += st;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (total_bad != 0 || total_st < 16) begin
      miscompares++;
      $display("[TB] FAIL sat_flow got bad=%0d stalls=%0d exp bad=0 stalls>=16", total_bad, total_st);
    end
    vectors++;
    if (stall_count !== {CW{1'b1}}) begin
      miscompares++;
      $display("[TB] FAIL sat_count got=%0d exp=%0d", stall_count, (2 ** CW) - 1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_dep();
    test_load_dep();
    test_youngest();
    test_reg_zero();
    test_flush_reset();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
